prio_arbiter: RTL and testbench



---
 rtl/prio_arbiter_pkg.sv | 31 +++
 rtl/prio_arbiter_if.sv | 30 +++
 rtl/prio_pick.sv | 21 ++
 rtl/prio_arbiter.sv | 118 +++++++++++
 tb/tb_prio_arbiter.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/prio_arbiter_pkg.sv
// Shared types and helpers for prio_arbiter: FSM state encoding and a
// highest-set-bit search over a vector of up to MaxN bits.
package prio_arbiter_pkg;

   localparam int unsigned MaxN = 64;
   localparam int unsigned MaxW = 6;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_e;

   typedef struct packed {
      logic            found;
      logic [MaxW-1:0] idx;
   } pick_t;

   // Ascending scan, so the last hit (highest index) is the one returned.
   function automatic pick_t highest_set(logic [MaxN-1:0] vec);
      pick_t res;
      res = '0;
      for (int unsigned i = 0; i < MaxN; i++) begin
         if (vec[i]) begin
            res.found = 1'b1;
            res.idx   = MaxW'(i);
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/prio_arbiter_if.sv
// Request/grant bundle between the requesters and prio_arbiter.
// master: requester side; slave: arbiter side.
interface prio_arbiter_if #(
   parameter int unsigned N = 8,
   parameter int unsigned W = $clog2(N)
) ();

   logic [N-1:0] req;
   logic         done;
   logic         gnt_valid;
   logic [W-1:0] gnt_idx;
   logic [N-1:0] gnt_onehot;

   modport master (
      output req,
      output done,
      input  gnt_valid,
      input  gnt_idx,
      input  gnt_onehot
   );

   modport slave (
      input  req,
      input  done,
      output gnt_valid,
      output gnt_idx,
      output gnt_onehot
   );

endinterface

// File: rtl/prio_pick.sv
// Combinational highest-set-bit finder over an N-bit vector (N <= MaxN).
module prio_pick
   import prio_arbiter_pkg::*;
#(
   parameter int unsigned N = 8,
   parameter int unsigned W = $clog2(N)
) (
   input  logic [N-1:0] vec_i,
   output logic         found_o,
   output logic [W-1:0] idx_o
);

   pick_t res;
   logic  unused_idx;

   assign res        = highest_set(MaxN'(vec_i));
   assign found_o    = res.found;
   assign idx_o      = res.idx[W-1:0];
   assign unused_idx = ^res.idx;

endmodule

// File: rtl/prio_arbiter.sv
// Registered N-way priority arbiter with sticky grant released by done.
// Define PRIO_ARBITER_RR_EN for round-robin search order; default is fixed MSB-first.
module prio_arbiter
   import prio_arbiter_pkg::*;
#(
   parameter int unsigned N = 8,
   parameter int unsigned W = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst_n,
   prio_arbiter_if.slave bus
);

   state_e       state_q, state_d;
   logic         gnt_valid_q, gnt_valid_d;
   logic [W-1:0] gnt_idx_q, gnt_idx_d;
   logic [N-1:0] gnt_onehot_q, gnt_onehot_d;

   logic [N-1:0] masked_req;
   logic [N-1:0] pick_vec;
   logic         pick_found;
   logic [W-1:0] pick_raw;
   logic [W-1:0] pick_idx;

   // gnt_onehot_q is zero in IDLE, so this only masks the releasing owner.
   assign masked_req = bus.req & ~gnt_onehot_q;

`ifdef PRIO_ARBITER_RR_EN
   logic [W-1:0] ptr_q, ptr_d;

   // Rotate so bit N-1 of pick_vec is requester p-1 and bit 0 is p itself.
   always_comb begin
      pick_vec = '0;
      for (int unsigned j = 0; j < N; j++) begin
         pick_vec[j] = masked_req[(j + 32'(ptr_q)) % N];
      end
   end

   assign pick_idx = W'((32'(pick_raw) + 32'(ptr_q)) % N);
`else
   assign pick_vec = masked_req;
   assign pick_idx = pick_raw;
`endif

   prio_pick #(
      .N(N),
      .W(W)
   ) u_pick (
      .vec_i  (pick_vec),
      .found_o(pick_found),
      .idx_o  (pick_raw)
   );

   always_comb begin
      state_d      = state_q;
      gnt_valid_d  = gnt_valid_q;
      gnt_idx_d    = gnt_idx_q;
      gnt_onehot_d = gnt_onehot_q;
`ifdef PRIO_ARBITER_RR_EN
      ptr_d        = ptr_q;
`endif
      unique case (state_q)
         ST_IDLE: begin
            if (pick_found) begin
               state_d      = ST_BUSY;
               gnt_valid_d  = 1'b1;
               gnt_idx_d    = pick_idx;
               gnt_onehot_d = N'(1) << pick_idx;
`ifdef PRIO_ARBITER_RR_EN
               ptr_d        = pick_idx;
`endif
            end
         end
         ST_BUSY: begin
            if (bus.done) begin
               if (pick_found) begin
                  gnt_idx_d    = pick_idx;
                  gnt_onehot_d = N'(1) << pick_idx;
`ifdef PRIO_ARBITER_RR_EN
                  ptr_d        = pick_idx;
`endif
               end else begin
                  state_d      = ST_IDLE;
                  gnt_valid_d  = 1'b0;
                  gnt_idx_d    = '0;
                  gnt_onehot_d = '0;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         gnt_valid_q  <= 1'b0;
         gnt_idx_q    <= '0;
         gnt_onehot_q <= '0;
`ifdef PRIO_ARBITER_RR_EN
         ptr_q        <= '0;
`endif
      end else begin
         state_q      <= state_d;
         gnt_valid_q  <= gnt_valid_d;
         gnt_idx_q    <= gnt_idx_d;
         gnt_onehot_q <= gnt_onehot_d;
`ifdef PRIO_ARBITER_RR_EN
         ptr_q        <= ptr_d;
`endif
      end
   end

   assign bus.gnt_valid  = gnt_valid_q;
   assign bus.gnt_idx    = gnt_idx_q;
   assign bus.gnt_onehot = gnt_onehot_q;

endmodule

// File: tb/tb_prio_arbiter.sv
// Bench for prio_arbiter (N=8): directed scenarios plus random traffic, checked by a
// queue-based scoreboard fed from a behavioural search-order model.
module tb_prio_arbiter;

   localparam int N = 8;

   typedef struct {
      logic       v;
      logic [2:0] idx;
      logic [7:0] oh;
   } exp_t;

   logic clk;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;
   exp_t exp_q[$];

   int m_owner;
   int m_ptr;

   prio_arbiter_if #(.N(N)) bus ();

   prio_arbiter #(.N(N)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // Walk the search order from the spec; the releasing owner (excl) is skipped.
   function automatic int arb(logic [7:0] r, int excl, int p);
      int c;
      for (int k = 1; k <= N; k++) begin
`ifdef PRIO_ARBITER_RR_EN
         c = (p - k + N) % N;
`else
         c = N - k;
`endif
         if (r[c] && c != excl) return c;
      end
      return -1;
   endfunction

   // Reference model: updates on each edge and queues the outputs it implies.
   always @(posedge clk or negedge rst_n) begin
      exp_t e;
      int   w;
      if (!rst_n) begin
         m_owner = -1;
         m_ptr   = 0;
         exp_q.delete();
      end else begin
         if (m_owner < 0) begin
            w = arb(bus.req, -1, m_ptr);
            if (w >= 0) begin
               m_owner = w;
               m_ptr   = w;
            end
         end else if (bus.done) begin
            w = arb(bus.req, m_owner, m_ptr);
            m_owner = w;
            if (w >= 0) m_ptr = w;
         end
         e.v   = (m_owner >= 0);
         e.idx = (m_owner >= 0) ? 3'(m_owner) : 3'd0;
         e.oh  = (m_owner >= 0) ? (8'd1 << m_owner) : 8'd0;
         exp_q.push_back(e);
      end
   end

   // Monitor: outputs are stable mid-cycle; compare against the oldest expectation.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("sb_valid", 32'(bus.gnt_valid), 32'(e.v));
         check("sb_idx", 32'(bus.gnt_idx), 32'(e.idx));
         check("sb_onehot", 32'(bus.gnt_onehot), 32'(e.oh));
      end
   end

   // Inputs change 1ns after an edge; returns 1ns after the following edge.
   task automatic drive(input logic [7:0] r, input logic d);
      bus.req  = r;
      bus.done = d;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      int exp_idx;
      logic [7:0] r;

      rst_n    = 1'b0;
      bus.req  = 8'hFF;
      bus.done = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_valid", 32'(bus.gnt_valid), 32'd0);
      check("rst_idx", 32'(bus.gnt_idx), 32'd0);
      check("rst_onehot", 32'(bus.gnt_onehot), 32'd0);
      bus.req = 8'h00;
      rst_n   = 1'b1;
      for (int i = 0; i < 5; i++) begin
         drive(8'h00, 1'b0);
         check("idle_valid", 32'(bus.gnt_valid), 32'd0);
      end

      drive(8'b0010_0100, 1'b0);
      check("fix_idx5", 32'(bus.gnt_idx), 32'd5);
      check("fix_oh20", 32'(bus.gnt_onehot), 32'h20);
      check("fix_valid", 32'(bus.gnt_valid), 32'd1);
      drive(8'h80, 1'b0);
      drive(8'h80, 1'b0);
      check("hold_idx5", 32'(bus.gnt_idx), 32'd5);
      drive(8'h80, 1'b1);
      check("handoff_idx7", 32'(bus.gnt_idx), 32'd7);
      check("handoff_valid", 32'(bus.gnt_valid), 32'd1);
      drive(8'h00, 1'b1);
      check("release_valid", 32'(bus.gnt_valid), 32'd0);

      drive(8'h08, 1'b0);
      check("sticky_idx3", 32'(bus.gnt_idx), 32'd3);
      for (int i = 0; i < 3; i++) drive(8'h00, 1'b0);
      check("sticky_hold", 32'(bus.gnt_idx), 32'd3);
      check("sticky_valid", 32'(bus.gnt_valid), 32'd1);
      drive(8'h00, 1'b1);
      check("sticky_rel_valid", 32'(bus.gnt_valid), 32'd0);
      check("sticky_rel_idx", 32'(bus.gnt_idx), 32'd0);

      do_reset();
      drive(8'hFF, 1'b0);
      check("seq_first", 32'(bus.gnt_idx), 32'd7);
      for (int k = 1; k <= 9; k++) begin
         drive(8'hFF, 1'b1);
`ifdef PRIO_ARBITER_RR_EN
         exp_idx = (7 - k + 16) % 8;
`else
         exp_idx = (k % 2 == 1) ? 6 : 7;
`endif
         check("seq_idx", 32'(bus.gnt_idx), 32'(exp_idx));
         check("seq_valid", 32'(bus.gnt_valid), 32'd1);
      end
      drive(8'h00, 1'b1);

      drive(8'h10, 1'b0);
      check("mid_idx4", 32'(bus.gnt_idx), 32'd4);
      bus.req = 8'h10;
      #2;
      rst_n = 1'b0;
      #1;
      check("async_valid", 32'(bus.gnt_valid), 32'd0);
      check("async_idx", 32'(bus.gnt_idx), 32'd0);
      check("async_onehot", 32'(bus.gnt_onehot), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      // With a stale pointer of 4, round-robin would pick 3 here.
      drive(8'h18, 1'b0);
      check("ptr_reset_idx4", 32'(bus.gnt_idx), 32'd4);
      drive(8'h00, 1'b1);

      drive(8'h01, 1'b0);
      check("self_idx0", 32'(bus.gnt_valid), 32'd1);
      drive(8'h01, 1'b1);
      check("self_gap", 32'(bus.gnt_valid), 32'd0);
      drive(8'h01, 1'b0);
      check("self_regrant", 32'(bus.gnt_valid), 32'd1);
      check("self_regrant_idx", 32'(bus.gnt_idx), 32'd0);

      for (int i = 0; i < 600; i++) begin
         r = 8'($urandom);
         if ($urandom_range(0, 5) == 0) r = 8'h00;
         drive(r, ($urandom_range(0, 2) == 0));
         if (i == 300) do_reset();
      end
      drive(8'h00, 1'b0);
      @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
